branch_predict_table: RTL and testbench

Parametrised dual-slot branch predictor for the two-wide fetch stage: a BHT of N-bit saturating counters, optional gshare history and a tagged BTB. The fetch stage presents one 8-byte-aligned bundle PC and gets a combinational taken/target answer for both slots in the same cycle. The EX stage writes back resolved branch outcomes through a single update port. A synchronous clear sweep re-initialises the tables without a reset.

---
 rtl/branch_predict_table_if.sv | 28 ++
 rtl/branch_predict_table.sv | 150 +++++++++++++++
 tb/tb_branch_predict_table.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/branch_predict_table_if.sv
// Fetch lookup, EX update and table-clear signals between the front end and
// the branch predictor.
interface branch_predict_table_if;
    logic [31:0] lk_pc;
    logic        lk0_hit;
    logic        lk1_hit;
    logic        lk0_taken;
    logic        lk1_taken;
    logic [31:0] lk0_target;
    logic [31:0] lk1_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_is_cond;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        clear;
    logic        busy;

    modport master (
        output lk_pc, upd_valid, upd_pc, upd_is_cond, upd_taken, upd_target, clear,
        input  lk0_hit, lk1_hit, lk0_taken, lk1_taken, lk0_target, lk1_target, busy
    );

    modport slave (
        input  lk_pc, upd_valid, upd_pc, upd_is_cond, upd_taken, upd_target, clear,
        output lk0_hit, lk1_hit, lk0_taken, lk1_taken, lk0_target, lk1_target, busy
    );
endinterface

// File: rtl/branch_predict_table.sv
// Dual-slot branch predictor: saturating-counter BHT with optional gshare
// history, tagged BTB, combinational lookup and a clear sweep FSM.
module branch_predict_table #(
    parameter int ENTRIES = 64,
    parameter int CTR_W   = 2,
    parameter int HIST_W  = 0,
    parameter int TAG_W   = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    branch_predict_table_if.slave  bp
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int GHR_W = (HIST_W > 0) ? HIST_W : 1;
    localparam logic [CTR_W-1:0] INIT    = CTR_W'((1 << (CTR_W - 1)) - 1);
    localparam logic [CTR_W-1:0] CTR_MAX = {CTR_W{1'b1}};

    typedef enum logic {IDLE, SWEEP} state_e;
    typedef logic [IDX_W-1:0] idx_t;
    typedef logic [TAG_W-1:0] tag_t;

    state_e           state_q, state_d;
    idx_t             sp_q, sp_d;
    logic [GHR_W-1:0] ghr_q, ghr_d;
    logic [CTR_W-1:0] ctr_q [ENTRIES];
    logic [CTR_W-1:0] ctr_d [ENTRIES];
    logic [ENTRIES-1:0] valid_q, valid_d;
    tag_t             btb_tag_q [ENTRIES];
    logic [29:0]      btb_tgt_q [ENTRIES];
    logic [ENTRIES-1:0] btb_jmp_q;

    logic busy;
    idx_t hist_ext;
    assign busy     = (state_q == SWEEP);
    assign bp.busy  = busy;
    // ghr_q is held at zero when history is disabled, so this folds to bi(pc).
    assign hist_ext = IDX_W'(ghr_q);

    // Lookup: both slots share the tag; slot1 differs from slot0 only in pc[2].
    tag_t lk_tag;
    idx_t lk_bi [2];
    idx_t lk_hi [2];
    logic lk_hit [2];
    logic lk_taken [2];
    logic [31:0] lk_target [2];

    assign lk_tag   = bp.lk_pc[TAG_W+IDX_W+1:IDX_W+2];
    assign lk_bi[0] = {bp.lk_pc[IDX_W+1:3], 1'b0};
    assign lk_bi[1] = {bp.lk_pc[IDX_W+1:3], 1'b1};

    always_comb begin
        for (int s = 0; s < 2; s++) begin
            lk_hi[s]     = lk_bi[s] ^ hist_ext;
            lk_hit[s]    = !busy && valid_q[lk_bi[s]] && (btb_tag_q[lk_bi[s]] == lk_tag);
            lk_taken[s]  = lk_hit[s] && (btb_jmp_q[lk_bi[s]] || ctr_q[lk_hi[s]][CTR_W-1]);
            lk_target[s] = lk_hit[s] ? {btb_tgt_q[lk_bi[s]], 2'b00} : 32'h0;
        end
    end

    assign bp.lk0_hit    = lk_hit[0];
    assign bp.lk1_hit    = lk_hit[1];
    assign bp.lk0_taken  = lk_taken[0];
    assign bp.lk1_taken  = lk_taken[1];
    assign bp.lk0_target = lk_target[0];
    assign bp.lk1_target = lk_target[1];

    // Update port.
    idx_t upd_bi, upd_hi;
    tag_t upd_tag;
    logic upd_fire;
    logic btb_we;

    assign upd_bi   = bp.upd_pc[IDX_W+1:2];
    assign upd_hi   = upd_bi ^ hist_ext;
    assign upd_tag  = bp.upd_pc[TAG_W+IDX_W+1:IDX_W+2];
    // A clear on the same edge wins: its valid/ghr wipe must not be undone.
    assign upd_fire = bp.upd_valid && !busy && !bp.clear;

    // NOTE: every variable gets its default first so no path leaves one
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_d = state_q;
        sp_d    = sp_q;
        ghr_d   = ghr_q;
        ctr_d   = ctr_q;
        valid_d = valid_q;
        btb_we  = 1'b0;
        if (bp.clear) begin
            state_d = SWEEP;
            sp_d    = '0;
            ghr_d   = '0;
            valid_d = '0;
        end else if (state_q == SWEEP) begin
            ctr_d[sp_q] = INIT;
            if (sp_q == idx_t'(ENTRIES - 1)) begin
                state_d = IDLE;
            end else begin
                sp_d = sp_q + 1'b1;
            end
        end else if (upd_fire) begin
            if (bp.upd_is_cond) begin
                if (bp.upd_taken && ctr_q[upd_hi] != CTR_MAX) begin
                    ctr_d[upd_hi] = ctr_q[upd_hi] + 1'b1;
                end else if (!bp.upd_taken && ctr_q[upd_hi] != '0) begin
                    ctr_d[upd_hi] = ctr_q[upd_hi] - 1'b1;
                end
                if (HIST_W > 0) begin
                    ghr_d = GHR_W'({ghr_q, bp.upd_taken});
                end
            end
            if (bp.upd_taken) begin
                valid_d[upd_bi] = 1'b1;
                btb_we          = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            sp_q    <= '0;
            ghr_q   <= '0;
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= INIT;
            end
        end else begin
            state_q <= state_d;
            sp_q    <= sp_d;
            ghr_q   <= ghr_d;
            valid_q <= valid_d;
            ctr_q   <= ctr_d;
        end
    end

    // NOTE: BTB payload is not reset; the valid bits qualify it, so it can
    // live in plain RAM without a reset path.
    always_ff @(posedge clk) begin
        if (btb_we) begin
            btb_tag_q[upd_bi] <= upd_tag;
            btb_tgt_q[upd_bi] <= bp.upd_target[31:2];
            btb_jmp_q[upd_bi] <= !bp.upd_is_cond;
        end
    end

    logic unused_ok;
    assign unused_ok = ^{bp.lk_pc, bp.upd_pc, bp.upd_target[1:0]};
endmodule

// File: tb/tb_branch_predict_table.sv
// Directed bench for branch_predict_table: a default instance (no history)
// and a HIST_W=2 instance, with hand-computed expected values.
module tb_branch_predict_table;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;
    int   n;

    always #5 clk = ~clk;

    branch_predict_table_if bp0();
    branch_predict_table_if bp1();

    branch_predict_table #(.ENTRIES(64), .CTR_W(2), .HIST_W(0), .TAG_W(8)) dut0 (
        .clk(clk), .rst(rst), .bp(bp0)
    );
    branch_predict_table #(.ENTRIES(64), .CTR_W(2), .HIST_W(2), .TAG_W(8)) dut1 (
        .clk(clk), .rst(rst), .bp(bp1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic upd0(input logic [31:0] pc, input logic cond, input logic tk, input logic [31:0] tgt);
        bp0.upd_valid = 1'b1; bp0.upd_pc = pc; bp0.upd_is_cond = cond;
        bp0.upd_taken = tk;   bp0.upd_target = tgt;
        tick();
        bp0.upd_valid = 1'b0;
    endtask

    task automatic upd1(input logic [31:0] pc, input logic cond, input logic tk, input logic [31:0] tgt);
        bp1.upd_valid = 1'b1; bp1.upd_pc = pc; bp1.upd_is_cond = cond;
        bp1.upd_taken = tk;   bp1.upd_target = tgt;
        tick();
        bp1.upd_valid = 1'b0;
    endtask

    task automatic look0(input string tag, input logic [31:0] pc,
                         input logic h0, input logic t0, input logic [31:0] g0,
                         input logic h1, input logic t1, input logic [31:0] g1);
        bp0.lk_pc = pc;
        #1;
        check({tag, ".hit0"},  32'(bp0.lk0_hit),   32'(h0));
        check({tag, ".tk0"},   32'(bp0.lk0_taken), 32'(t0));
        check({tag, ".tgt0"},  bp0.lk0_target,     g0);
        check({tag, ".hit1"},  32'(bp0.lk1_hit),   32'(h1));
        check({tag, ".tk1"},   32'(bp0.lk1_taken), 32'(t1));
        check({tag, ".tgt1"},  bp0.lk1_target,     g1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        bp0.lk_pc = 32'h100; bp0.upd_valid = 0; bp0.upd_pc = 0; bp0.upd_is_cond = 0;
        bp0.upd_taken = 0; bp0.upd_target = 0; bp0.clear = 0;
        bp1.lk_pc = 32'h10; bp1.upd_valid = 0; bp1.upd_pc = 0; bp1.upd_is_cond = 0;
        bp1.upd_taken = 0; bp1.upd_target = 0; bp1.clear = 0;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        tick();
        check("rst.busy", 32'(bp0.busy), 32'd0);
        look0("rst", 32'h100, 0, 0, 0, 0, 0, 0);

        // Same-cycle lookup sees pre-update state.
        bp0.upd_valid = 1'b1; bp0.upd_pc = 32'h100; bp0.upd_is_cond = 1'b1;
        bp0.upd_taken = 1'b1; bp0.upd_target = 32'h80;
        #1;
        check("nobypass.hit0", 32'(bp0.lk0_hit), 32'd0);
        tick();
        bp0.upd_valid = 1'b0;
        look0("first", 32'h100, 1, 1, 32'h80, 0, 0, 0);

        // Counter walk: 10 -> 11 -> 11 (sat) -> 10 -> 01 -> 00 -> 00 (sat).
        upd0(32'h100, 1, 1, 32'h80);
        check("c11.tk0", 32'(bp0.lk0_taken), 32'd1);
        upd0(32'h100, 1, 1, 32'h80);
        check("c11s.tk0", 32'(bp0.lk0_taken), 32'd1);
        upd0(32'h100, 1, 0, 32'h0);
        check("c10.tk0", 32'(bp0.lk0_taken), 32'd1);
        upd0(32'h100, 1, 0, 32'h0);
        check("c01.tk0", 32'(bp0.lk0_taken), 32'd0);
        check("c01.hit0", 32'(bp0.lk0_hit), 32'd1);
        upd0(32'h100, 1, 0, 32'h0);
        upd0(32'h100, 1, 0, 32'h0);
        check("c00.hit0", 32'(bp0.lk0_hit), 32'd1);
        check("c00.tgt0", bp0.lk0_target, 32'h80);
        upd0(32'h100, 1, 1, 32'h80);
        check("c00to01.tk0", 32'(bp0.lk0_taken), 32'd0);
        upd0(32'h100, 1, 1, 32'h80);
        check("c01to10.tk0", 32'(bp0.lk0_taken), 32'd1);

        // Tag mismatch on the same index.
        look0("tagmiss", 32'h200, 0, 0, 0, 0, 0, 0);

        // jal forces taken; its counter stays at INIT.
        upd0(32'h104, 0, 1, 32'h200);
        look0("jal", 32'h100, 1, 1, 32'h80, 1, 1, 32'h200);
        upd0(32'h104, 1, 1, 32'h300);
        check("jalctr.tk1", 32'(bp0.lk1_taken), 32'd1);
        check("jalctr.tgt1", bp0.lk1_target, 32'h300);
        upd0(32'h104, 1, 0, 32'h0);
        check("jalctr2.tk1", 32'(bp0.lk1_taken), 32'd0);
        check("jalctr2.hit1", 32'(bp0.lk1_hit), 32'd1);

        // gshare: ghr 00 -> 01 -> 11, then pc 0x10 trains index 4^3=7.
        upd1(32'h0, 1, 1, 32'h20);
        upd1(32'h0, 1, 1, 32'h20);
        upd1(32'h10, 1, 1, 32'h40);
        bp1.lk_pc = 32'h10;
        #1;
        check("hist.hit0", 32'(bp1.lk0_hit), 32'd1);
        check("hist.tk0", 32'(bp1.lk0_taken), 32'd1);
        check("hist.tgt0", bp1.lk0_target, 32'h40);
        check("hist.hit1", 32'(bp1.lk1_hit), 32'd0);

        // Clear sweep with a taken update injected mid-sweep.
        bp0.lk_pc = 32'h100;
        bp0.clear = 1'b1;
        tick();
        bp0.clear = 1'b0;
        check("sweep.busy", 32'(bp0.busy), 32'd1);
        n = 0;
        while (bp0.busy && n < 200) begin
            if (n == 5) begin
                check("sweep.hit0", 32'(bp0.lk0_hit), 32'd0);
                check("sweep.tgt0", bp0.lk0_target, 32'd0);
            end
            bp0.upd_valid  = (n == 10);
            bp0.upd_pc     = 32'h100;
            bp0.upd_is_cond = 1'b1;
            bp0.upd_taken  = 1'b1;
            bp0.upd_target = 32'h500;
            n++;
            tick();
        end
        bp0.upd_valid = 1'b0;
        check("sweep.len", 32'(n), 32'd64);
        look0("postsweep", 32'h100, 0, 0, 0, 0, 0, 0);
        upd0(32'h100, 1, 1, 32'h80);
        check("init.tk0", 32'(bp0.lk0_taken), 32'd1);
        upd0(32'h100, 1, 0, 32'h0);
        check("init2.tk0", 32'(bp0.lk0_taken), 32'd0);

        // Restart at sp=30: 31 + 64 busy cycles.
        bp0.clear = 1'b1;
        tick();
        bp0.clear = 1'b0;
        n = 0;
        while (bp0.busy && n < 300) begin
            bp0.clear = (n == 30);
            n++;
            tick();
        end
        bp0.clear = 1'b0;
        check("restart.len", 32'(n), 32'd95);
        check("restart.hit0", 32'(bp0.lk0_hit), 32'd0);

        // Asynchronous reset mid-sweep.
        bp0.clear = 1'b1;
        tick();
        bp0.clear = 1'b0;
        repeat (5) tick();
        check("midrst.busy_pre", 32'(bp0.busy), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("midrst.busy", 32'(bp0.busy), 32'd0);
        tick();
        rst = 1'b1;
        tick();
        check("midrst.busy_post", 32'(bp0.busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
